// File: rtl/ebus_diag_edp_reader.sv
// EBUS-side initiator for EDP diagnostic reads: strobes DIAG_FUNC, waits for a settled EBUS, returns the word.
// Build option EBUS_DIAG_TIMEOUT_EN adds a per-register timeout that answers with a zero word and rsp_timeout.
module ebus_diag_edp_reader #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_func,
    input  logic        req_all,
    output logic        diag_read_func_12x,
    output logic [2:0]  diag_func,
    input  logic        ebus_driving,
    input  logic [35:0] ebus_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [35:0] rsp_data,
    output logic [2:0]  rsp_func,
    output logic        rsp_timeout,
    output logic        rsp_last,
    output logic        busy
);
    // state  | meaning
    // IDLE   | waiting for a request
    // STROBE | strobe high, counting settled EBUS cycles
    // RESP   | response held until accepted
    // GAP    | one strobe-low cycle so the EDP releases the EBUS
    typedef enum logic [1:0] {IDLE, STROBE, RESP, GAP} state_t;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    generate
        if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES <= SETTLE_CYCLES) begin : g_param_check
            $error("ebus_diag_edp_reader: invalid SETTLE_CYCLES/TIMEOUT_CYCLES");
        end
    endgenerate

    state_t          state, state_nxt;
    logic [SW-1:0]   settle_cnt;
    logic [2:0]      sel;
    logic            scan_all;
    logic            capture;
    logic            timeout_hit;

    assign capture = (state == STROBE) && ebus_driving &&
                     (settle_cnt == SW'(SETTLE_CYCLES - 1));

`ifdef EBUS_DIAG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    assign timeout_hit = (state == STROBE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == STROBE) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = STROBE;
            STROBE:  if (capture || timeout_hit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = rsp_last ? IDLE : GAP;
            GAP:     state_nxt = STROBE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt  <= '0;
            sel         <= 3'd0;
            scan_all    <= 1'b0;
            rsp_data    <= '0;
            rsp_func    <= 3'd0;
            rsp_timeout <= 1'b0;
            rsp_last    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        scan_all   <= req_all;
                        sel        <= req_all ? 3'd0 : req_func;
                        settle_cnt <= '0;
                    end
                end
                STROBE: begin
                    settle_cnt <= ebus_driving ? settle_cnt + SW'(1) : '0;
                    // capture takes priority when both land on the same edge
                    if (capture) begin
                        rsp_data    <= ebus_data;
                        rsp_timeout <= 1'b0;
                        rsp_func    <= sel;
                        rsp_last    <= !scan_all || (sel == 3'd7);
                    end else if (timeout_hit) begin
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_func    <= sel;
                        rsp_last    <= !scan_all || (sel == 3'd7);
                    end
                end
                RESP: begin
                    if (rsp_ready && !rsp_last) begin
                        sel <= sel + 3'd1;
                    end
                end
                GAP: begin
                    settle_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready          = (state == IDLE);
    assign busy               = (state != IDLE);
    assign rsp_valid          = (state == RESP);
    assign diag_read_func_12x = (state == STROBE);
    assign diag_func          = (state == STROBE) ? sel : 3'd0;

endmodule

// File: tb/tb_ebus_diag_edp_reader.sv
// Bench for ebus_diag_edp_reader: a behavioural EDP drives the EBUS from a random data table and
// each scenario task checks the DUT against cycle counts and words derived from the read rules.
module tb_ebus_diag_edp_reader;
    localparam int S = 2;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_func = 3'd0;
    logic        req_all = 1'b0;
    logic        diag_read_func_12x;
    logic [2:0]  diag_func;
    logic        ebus_driving;
    logic [35:0] ebus_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [35:0] rsp_data;
    logic [2:0]  rsp_func;
    logic        rsp_timeout;
    logic        rsp_last;
    logic        busy;

    logic        follow = 1'b1;
    logic        drive_val = 1'b0;
    logic        block_en = 1'b0;
    logic [2:0]  block_f = 3'd0;
    logic [35:0] data_tab [8];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // EDP model: drives the bus while strobed (optionally silent for one select), data per select
    assign ebus_driving = follow ? (diag_read_func_12x && !(block_en && diag_func == block_f)) : drive_val;
    assign ebus_data    = data_tab[diag_func];

    ebus_diag_edp_reader #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_func(req_func),
        .req_all(req_all),
        .diag_read_func_12x(diag_read_func_12x),
        .diag_func(diag_func),
        .ebus_driving(ebus_driving),
        .ebus_data(ebus_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_func(rsp_func),
        .rsp_timeout(rsp_timeout),
        .rsp_last(rsp_last),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_table();
        for (int i = 0; i < 8; i++) data_tab[i] = 36'({$urandom(), $urandom()});
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        total++;
        if ({req_ready, busy, diag_read_func_12x, rsp_valid} !== 4'b1000)
            $display("FAIL reset_ctrl: got %b expected 1000", {req_ready, busy, diag_read_func_12x, rsp_valid});
        if ({req_ready, busy, diag_read_func_12x, rsp_valid} !== 4'b1000) bad++;
        total++;
        if ({diag_func, rsp_func, rsp_timeout, rsp_last} !== 8'd0) begin
            $display("FAIL reset_fields: got %h expected 00", {diag_func, rsp_func, rsp_timeout, rsp_last});
            bad++;
        end
        total++;
        if (rsp_data !== 36'd0) begin
            $display("FAIL reset_data: got %h expected 0", rsp_data);
            bad++;
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic do_single(input logic [2:0] f, input string name);
        total++;
        if (req_ready !== 1'b1) begin
            $display("FAIL %s_ready: got %b expected 1", name, req_ready);
            bad++;
        end
        req_all = 1'b0;
        req_func = f;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= S + 1; k++) begin
            total++;
            if (diag_read_func_12x !== (k <= S)) begin
                $display("FAIL %s_strobe c%0d: got %b expected %b", name, k, diag_read_func_12x, (k <= S));
                bad++;
            end
            if (k <= S) begin
                total++;
                if (diag_func !== f) begin
                    $display("FAIL %s_func c%0d: got %0d expected %0d", name, k, diag_func, f);
                    bad++;
                end
            end
            total++;
            if (rsp_valid !== (k == S + 1)) begin
                $display("FAIL %s_valid c%0d: got %b expected %b", name, k, rsp_valid, (k == S + 1));
                bad++;
            end
            if (k <= S) tick();
        end
        total++;
        if ({rsp_func, rsp_last, rsp_timeout} !== {f, 2'b10}) begin
            $display("FAIL %s_rsp: got %b expected %b", name, {rsp_func, rsp_last, rsp_timeout}, {f, 2'b10});
            bad++;
        end
        total++;
        if (rsp_data !== data_tab[f]) begin
            $display("FAIL %s_data: got %o expected %o", name, rsp_data, data_tab[f]);
            bad++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL %s_done: got ready=%b valid=%b expected 1 0", name, req_ready, rsp_valid);
            bad++;
        end
    endtask

    task automatic test_single();
        logic [2:0] f;
        follow = 1'b1;
        randomize_table();
        data_tab[3] = 36'o123456654321;
        do_single(3'd3, "single_f3");
        for (int i = 0; i < 4; i++) begin
            f = 3'($urandom_range(0, 7));
            do_single(f, "single_rand");
        end
    endtask

    task automatic test_glitch();
        logic       pat [1:40];
        int         run;
        int         c;
        logic [2:0] f;
        follow = 1'b0;
        for (int it = 0; it < 5; it++) begin
            for (int k = 1; k <= 40; k++) pat[k] = 1'b1;
            if (it == 0) pat[2] = 1'b0;
            else for (int k = 1; k <= 10; k++) pat[k] = 1'($urandom_range(0, 1));
            run = 0;
            c = 0;
            for (int k = 1; k <= 40; k++) begin
                if (c == 0) begin
                    run = pat[k] ? run + 1 : 0;
                    if (run == S) c = k;
                end
            end
            f = (it == 0) ? 3'd5 : 3'($urandom_range(0, 7));
            drive_val = 1'b0;
            req_all = 1'b0;
            req_func = f;
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            for (int k = 1; k <= c + 1; k++) begin
                drive_val = pat[k];
                total++;
                if (diag_read_func_12x !== (k <= c)) begin
                    $display("FAIL glitch_strobe it%0d c%0d: got %b expected %b", it, k, diag_read_func_12x, (k <= c));
                    bad++;
                end
                total++;
                if (rsp_valid !== (k == c + 1)) begin
                    $display("FAIL glitch_valid it%0d c%0d: got %b expected %b", it, k, rsp_valid, (k == c + 1));
                    bad++;
                end
                if (k <= c) tick();
            end
            total++;
            if (rsp_data !== data_tab[f] || rsp_func !== f) begin
                $display("FAIL glitch_rsp it%0d: got %o/%0d expected %o/%0d", it, rsp_data, rsp_func, data_tab[f], f);
                bad++;
            end
            drive_val = 1'b0;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        follow = 1'b1;
    endtask

    task automatic test_scan(input bit stall_third, input bit check_timing, input string name);
        int         idx;
        int         cyc;
        int         stall;
        bit         seen;
        bit         gap_check;
        bit         done;
        logic [2:0] ef;
        logic       et;
        logic [35:0] ed;
        follow = 1'b1;
        req_all = 1'b1;
        req_func = 3'($urandom_range(0, 7));
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        cyc = 1;
        idx = 0;
        stall = 0;
        seen = 1'b0;
        gap_check = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            ef = 3'(idx);
            et = block_en && (ef == block_f);
            ed = et ? 36'd0 : data_tab[ef];
            total++;
            if (diag_read_func_12x && rsp_valid) begin
                $display("FAIL %s_overlap c%0d: strobe and rsp_valid both high", name, cyc);
                bad++;
            end
            if (gap_check) begin
                total++;
                if (diag_read_func_12x !== 1'b0 || rsp_valid !== 1'b0) begin
                    $display("FAIL %s_gap c%0d: got strobe=%b valid=%b expected 0 0", name, cyc, diag_read_func_12x, rsp_valid);
                    bad++;
                end
                gap_check = 1'b0;
            end
            if (rsp_valid) begin
                total++;
                if ({rsp_func, rsp_last, rsp_timeout} !== {ef, (ef == 3'd7), et}) begin
                    $display("FAIL %s_rsp%0d: got %b expected %b", name, idx, {rsp_func, rsp_last, rsp_timeout}, {ef, (ef == 3'd7), et});
                    bad++;
                end
                total++;
                if (rsp_data !== ed) begin
                    $display("FAIL %s_data%0d: got %o expected %o", name, idx, rsp_data, ed);
                    bad++;
                end
                if (!seen) begin
                    seen = 1'b1;
                    stall = (stall_third && idx == 2) ? 5 : 0;
                    if (check_timing) begin
                        total++;
                        if (cyc != idx * (S + 2) + S + 1) begin
                            $display("FAIL %s_timing%0d: got cycle %0d expected %0d", name, idx, cyc, idx * (S + 2) + S + 1);
                            bad++;
                        end
                    end
                end
                if (stall > 0) begin
                    rsp_ready = 1'b0;
                    stall--;
                    tick();
                    cyc++;
                end else begin
                    rsp_ready = 1'b1;
                    tick();
                    cyc++;
                    rsp_ready = 1'b0;
                    seen = 1'b0;
                    if (idx == 7) done = 1'b1;
                    else gap_check = 1'b1;
                    idx++;
                end
            end else begin
                if (seen) begin
                    total++;
                    $display("FAIL %s_dropped%0d: rsp_valid fell before acceptance", name, idx);
                    bad++;
                    seen = 1'b0;
                end
                rsp_ready = 1'($urandom_range(0, 1));
                tick();
                cyc++;
            end
        end
        rsp_ready = 1'b0;
        total++;
        if (!done) begin
            $display("FAIL %s_bound: got %0d responses expected 8", name, idx);
            bad++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            $display("FAIL %s_idle: got req_ready=%b expected 1", name, req_ready);
            bad++;
        end
        req_all = 1'b0;
    endtask

`ifdef EBUS_DIAG_TIMEOUT_EN
    task automatic test_timeout();
        logic [2:0] f;
        f = 3'($urandom_range(0, 7));
        follow = 1'b0;
        drive_val = 1'b0;
        req_all = 1'b0;
        req_func = f;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= T + 1; k++) begin
            total++;
            if (rsp_valid !== (k == T + 1) || diag_read_func_12x !== (k <= T)) begin
                $display("FAIL timeout_seq c%0d: got valid=%b strobe=%b expected %b %b", k, rsp_valid, diag_read_func_12x, (k == T + 1), (k <= T));
                bad++;
            end
            if (k <= T) tick();
        end
        total++;
        if ({rsp_func, rsp_last, rsp_timeout} !== {f, 2'b11} || rsp_data !== 36'd0) begin
            $display("FAIL timeout_rsp: got %b/%o expected %b/0", {rsp_func, rsp_last, rsp_timeout}, rsp_data, {f, 2'b11});
            bad++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        follow = 1'b1;
        block_en = 1'b1;
        block_f = 3'($urandom_range(0, 7));
        randomize_table();
        test_scan(1'b0, 1'b0, "scan_tmo");
        block_en = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        logic [2:0] f;
        f = 3'($urandom_range(0, 7));
        follow = 1'b0;
        drive_val = 1'b0;
        req_all = 1'b0;
        req_func = f;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            total++;
            if (rsp_valid !== 1'b0 || diag_read_func_12x !== 1'b1) begin
                $display("FAIL notmo_wait c%0d: got valid=%b strobe=%b expected 0 1", k, rsp_valid, diag_read_func_12x);
                bad++;
            end
            tick();
        end
        drive_val = 1'b1;
        for (int k = 101; k <= 103; k++) begin
            total++;
            if (rsp_valid !== (k == 103)) begin
                $display("FAIL notmo_valid c%0d: got %b expected %b", k, rsp_valid, (k == 103));
                bad++;
            end
            if (k < 103) tick();
        end
        total++;
        if (rsp_data !== data_tab[f] || rsp_timeout !== 1'b0) begin
            $display("FAIL notmo_rsp: got %o/%b expected %o/0", rsp_data, rsp_timeout, data_tab[f]);
            bad++;
        end
        drive_val = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        follow = 1'b1;
    endtask
`endif

    task automatic test_reset_mid_scan();
        bit found;
        follow = 1'b1;
        found = 1'b0;
        rsp_ready = 1'b1;
        req_all = 1'b1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (diag_read_func_12x && diag_func == 3'd4) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!found) begin
            $display("FAIL rstmid_reach: got no strobe of select 4 expected one");
            bad++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({diag_read_func_12x, busy, rsp_valid, req_ready} !== 4'b0001 || diag_func !== 3'd0) begin
            $display("FAIL rstmid_async: got %b/%0d expected 0001/0", {diag_read_func_12x, busy, rsp_valid, req_ready}, diag_func);
            bad++;
        end
        rsp_ready = 1'b0;
        req_all = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        randomize_table();
        do_single(3'd0, "after_reset");
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        randomize_table();
        test_reset();
        test_single();
        test_glitch();
        for (int i = 0; i < 8; i++) data_tab[i] = 36'(i);
        test_scan(1'b1, 1'b0, "scan_bp");
        randomize_table();
        test_scan(1'b0, 1'b1, "scan_full");
`ifdef EBUS_DIAG_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
